// File: rtl/hpdcache_sram_ctrl_pkg.sv
// Shared types for the single-port SRAM controller: FSM states and port count.
package hpdcache_sram_ctrl_pkg;

  localparam int unsigned NPORTS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/hpdcache_sram_ctrl_rrarb.sv
// Two-input round-robin arbiter; the pointer names the port that wins a tie
// and always moves to the port that was not granted.
module hpdcache_sram_ctrl_rrarb
  import hpdcache_sram_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [NPORTS-1:0] req_i,
  output logic [NPORTS-1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    if (en_i) begin
      if (&req_i) begin
        gnt_o[ptr_q] = 1'b1;
        ptr_d        = ~ptr_q;
      end else if (req_i[0]) begin
        gnt_o = 2'b01;
        ptr_d = 1'b1;
      end else if (req_i[1]) begin
        gnt_o = 2'b10;
        ptr_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/hpdcache_sram_1rw_ctrl.sv
// Two-port front end for a single-port (1RW) SRAM with optional zero-fill after reset.
// Handshake: a request transfers in a cycle where req_valid_i[p] and req_ready_o[p] are both 1; until then the requester holds it stable.
module hpdcache_sram_1rw_ctrl
  import hpdcache_sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_SIZE     = 6,
  parameter int unsigned DATA_SIZE     = 64,
  parameter int unsigned NDATA         = 1,
  parameter int unsigned DEPTH         = 2**ADDR_SIZE,
  parameter int unsigned INIT_ON_RESET = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NPORTS-1:0]                         req_valid_i,
  output logic [NPORTS-1:0]                         req_ready_o,
  input  logic [NPORTS-1:0]                         req_we_i,
  input  logic [NPORTS-1:0][ADDR_SIZE-1:0]          req_addr_i,
  input  logic [NPORTS-1:0][NDATA*DATA_SIZE-1:0]    req_wdata_i,
  input  logic [NPORTS-1:0][NDATA*DATA_SIZE/8-1:0]  req_wbe_i,
  output logic [NPORTS-1:0]                         rsp_valid_o,
  output logic [NDATA*DATA_SIZE-1:0]                rsp_rdata_o,
  output logic                                      sram_cs_o,
  output logic                                      sram_we_o,
  output logic [ADDR_SIZE-1:0]                      sram_addr_o,
  output logic [NDATA*DATA_SIZE-1:0]                sram_wdata_o,
  output logic [NDATA*DATA_SIZE/8-1:0]              sram_wbyteenable_o,
  input  logic [NDATA*DATA_SIZE-1:0]                sram_rdata_i,
  output logic                                      init_done_o,
  output ctrl_state_e                               dbg_state_o
);

  localparam logic [ADDR_SIZE-1:0] LAST_ROW = ADDR_SIZE'(DEPTH - 1);

  ctrl_state_e          state_q, state_d;
  logic [ADDR_SIZE-1:0] cnt_q, cnt_d;
  logic [NPORTS-1:0]    rsp_valid_q, rsp_valid_d;
  logic                 init_done_q, init_done_d;
  logic [NPORTS-1:0]    gnt;

  // Arbitration is frozen while reset is high so stale RUN state grants nothing.
  hpdcache_sram_ctrl_rrarb u_rrarb (
    .clk   (clk),
    .rst   (rst),
    .en_i  ((state_q == RUN) && !rst),
    .req_i (req_valid_i),
    .gnt_o (gnt)
  );

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    sram_cs_o          = 1'b0;
    sram_we_o          = 1'b0;
    sram_addr_o        = '0;
    sram_wdata_o       = '0;
    sram_wbyteenable_o = '0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = (INIT_ON_RESET != 0) ? INIT : RUN;
      end
      INIT: begin
        sram_cs_o          = 1'b1;
        sram_we_o          = 1'b1;
        sram_addr_o        = cnt_q;
        sram_wbyteenable_o = '1;
        cnt_d              = cnt_q + ADDR_SIZE'(1);
        if (cnt_q == LAST_ROW) begin
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned p = 0; p < NPORTS; p++) begin
          if (gnt[p]) begin
            sram_cs_o          = 1'b1;
            sram_we_o          = req_we_i[p];
            sram_addr_o        = req_addr_i[p];
            sram_wdata_o       = req_wdata_i[p];
            sram_wbyteenable_o = req_wbe_i[p];
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) sram_cs_o = 1'b0;
    rsp_valid_d = gnt & ~req_we_i;
    init_done_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      init_done_q <= init_done_d;
    end
  end

  // Gating with rst kills a response whose read was granted just before reset.
  assign req_ready_o = gnt;
  assign rsp_valid_o = rsp_valid_q & {NPORTS{~rst}};
  assign rsp_rdata_o = sram_rdata_i;
  assign init_done_o = init_done_q & ~rst;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hpdcache_sram_1rw_ctrl.sv
// Bench for hpdcache_sram_1rw_ctrl: SRAM model, round-robin/memory reference model, scenario tasks.
module tb_hpdcache_sram_1rw_ctrl;
  import hpdcache_sram_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        req_valid, req_ready, req_we, rsp_valid;
  logic [1:0][2:0]   req_addr;
  logic [1:0][31:0]  req_wdata;
  logic [1:0][3:0]   req_wbe;
  logic [31:0]       rsp_rdata, sram_wdata, sram_rdata;
  logic              sram_cs, sram_we, init_done;
  logic [2:0]        sram_addr;
  logic [3:0]        sram_wbe;
  ctrl_state_e       dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] sram_mem [8];
  logic [31:0] exp_mem [8];
  logic [32:0] exp_q [$];
  logic        m_ptr;

  hpdcache_sram_1rw_ctrl #(
    .ADDR_SIZE(3), .DATA_SIZE(32), .NDATA(1), .DEPTH(8), .INIT_ON_RESET(1)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .req_we_i           (req_we),
    .req_addr_i         (req_addr),
    .req_wdata_i        (req_wdata),
    .req_wbe_i          (req_wbe),
    .rsp_valid_o        (rsp_valid),
    .rsp_rdata_o        (rsp_rdata),
    .sram_cs_o          (sram_cs),
    .sram_we_o          (sram_we),
    .sram_addr_o        (sram_addr),
    .sram_wdata_o       (sram_wdata),
    .sram_wbyteenable_o (sram_wbe),
    .sram_rdata_i       (sram_rdata),
    .init_done_o        (init_done),
    .dbg_state_o        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- SRAM model (registered read, held until next read) ----------------
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_wbe[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  // ---------------- driver / reference model ----------------
  task automatic idle_inputs();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wbe = '0;
  endtask

  // Round-robin rule: a tie goes to the pointed port, and the pointer then names the loser.
  task automatic model_arb(input logic [1:0] v, output logic [1:0] g);
    g = 2'b00;
    if (v == 2'b11) begin
      g = m_ptr ? 2'b10 : 2'b01;
      m_ptr = ~m_ptr;
    end else if (v != 2'b00) begin
      g = v;
      m_ptr = v[0];
    end
  endtask

  task automatic model_write(input int p);
    for (int b = 0; b < 4; b++)
      if (req_wbe[p][b]) exp_mem[req_addr[p]][8*b +: 8] = req_wdata[p][8*b +: 8];
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({sram_cs, init_done, rsp_valid, req_ready} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got cs/done/rsp/rdy=%b expected 000000",
               {sram_cs, init_done, rsp_valid, req_ready});
    end
    n_cmp++;
    if (dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
  endtask

  // Releases reset (already asserted by the caller) and checks the full zero-fill.
  task automatic test_init(input string tag);
    logic [1:0] g;
    m_ptr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    req_valid = 2'b01;
    req_addr[0] = 3'd6;
    #1;
    n_cmp++;
    if ({sram_cs, req_ready, init_done} !== 4'b0) begin
      n_err++;
      $display("FAIL %s_idle: got cs/rdy/done=%b expected 0000", tag, {sram_cs, req_ready, init_done});
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({sram_cs, sram_we, sram_addr, sram_wdata, sram_wbe} !== {1'b1, 1'b1, 3'(i), 32'h0, 4'hF}) begin
        n_err++;
        $display("FAIL %s_row%0d: got cs/we/addr/wdata/wbe=%h expected %h", tag, i,
                 {sram_cs, sram_we, sram_addr, sram_wdata, sram_wbe}, {1'b1, 1'b1, 3'(i), 32'h0, 4'hF});
      end
      n_cmp++;
      if ({req_ready, init_done} !== 3'b0) begin
        n_err++;
        $display("FAIL %s_busy%0d: got rdy/done=%b expected 000", tag, i, {req_ready, init_done});
      end
    end
    for (int a = 0; a < 8; a++) exp_mem[a] = 32'h0;
    @(negedge clk);
    #1;
    model_arb(req_valid, g);
    n_cmp++;
    if ({init_done, req_ready, sram_cs, sram_addr} !== {1'b1, g, 1'b1, 3'd6}) begin
      n_err++;
      $display("FAIL %s_done: got done/rdy/cs/addr=%b expected %b", tag,
               {init_done, req_ready, sram_cs, sram_addr}, {1'b1, g, 1'b1, 3'd6});
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_rdata} !== {2'b01, exp_mem[6]}) begin
      n_err++;
      $display("FAIL %s_held_read: got %h expected %h", tag, {rsp_valid, rsp_rdata}, {2'b01, exp_mem[6]});
    end
  endtask

  task automatic test_read_zero();
    logic [1:0] g;
    @(negedge clk);
    req_valid = 2'b01; req_we = 2'b00; req_addr[0] = 3'd3;
    #1;
    model_arb(req_valid, g);
    n_cmp++;
    if ({req_ready, sram_cs, sram_we, sram_addr} !== {g, 1'b1, 1'b0, 3'd3}) begin
      n_err++;
      $display("FAIL read0_grant: got %b expected %b", {req_ready, sram_cs, sram_we, sram_addr}, {g, 1'b1, 1'b0, 3'd3});
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_rdata} !== {2'b01, 32'h0}) begin
      n_err++;
      $display("FAIL read0_rsp: got %h expected %h", {rsp_valid, rsp_rdata}, {2'b01, 32'h0});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (rsp_valid !== 2'b00) begin
      n_err++;
      $display("FAIL read0_one_cycle: got rsp_valid=%b expected 00", rsp_valid);
    end
  endtask

  task automatic test_write_read();
    logic [1:0] g;
    @(negedge clk);
    req_valid = 2'b01; req_we = 2'b01; req_addr[0] = 3'd5;
    req_wdata[0] = 32'hAABBCCDD; req_wbe[0] = 4'h5;
    #1;
    model_arb(req_valid, g);
    n_cmp++;
    if ({req_ready, sram_cs, sram_we, sram_addr, sram_wdata, sram_wbe} !==
        {g, 1'b1, 1'b1, 3'd5, 32'hAABBCCDD, 4'h5}) begin
      n_err++;
      $display("FAIL write_drive: got %h expected %h", {req_ready, sram_cs, sram_we, sram_addr, sram_wdata, sram_wbe},
               {g, 1'b1, 1'b1, 3'd5, 32'hAABBCCDD, 4'h5});
    end
    model_write(0);
    @(negedge clk);
    idle_inputs();
    req_valid = 2'b10; req_addr[1] = 3'd5;
    #1;
    model_arb(req_valid, g);
    n_cmp++;
    if ({rsp_valid, req_ready, sram_cs, sram_we, sram_addr} !== {2'b00, g, 1'b1, 1'b0, 3'd5}) begin
      n_err++;
      $display("FAIL read1_grant: got %b expected %b", {rsp_valid, req_ready, sram_cs, sram_we, sram_addr},
               {2'b00, g, 1'b1, 1'b0, 3'd5});
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_rdata} !== {2'b10, 32'h00BB00DD}) begin
      n_err++;
      $display("FAIL write_read_data: got %h expected %h", {rsp_valid, rsp_rdata}, {2'b10, 32'h00BB00DD});
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  g, ev;
    logic [32:0] e;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      idle_inputs();
      if (c < 6) begin
        req_valid = 2'b11;
        req_addr[0] = 3'(c);
        req_addr[1] = 3'(7 - c);
      end
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        ev = e[32] ? 2'b10 : 2'b01;
        n_cmp++;
        if ({rsp_valid, rsp_rdata} !== {ev, e[31:0]}) begin
          n_err++;
          $display("FAIL b2b_rsp%0d: got %h expected %h", c, {rsp_valid, rsp_rdata}, {ev, e[31:0]});
        end
      end
      model_arb(req_valid, g);
      n_cmp++;
      if (req_ready !== g || (c < 6 && g !== ((c % 2 == 0) ? 2'b01 : 2'b10))) begin
        n_err++;
        $display("FAIL b2b_grant%0d: got %b expected %b", c, req_ready, g);
      end
      for (int p = 0; p < 2; p++)
        if (g[p]) exp_q.push_back({1'(p), exp_mem[req_addr[p]]});
    end
  endtask

  task automatic test_random();
    logic [1:0]  g, ev, pend;
    logic [32:0] e;
    int          p;
    pend = 2'b00;
    for (int c = 0; c < 301; c++) begin
      @(negedge clk);
      for (int q = 0; q < 2; q++) begin
        if (!pend[q] && c < 300 && $urandom_range(0, 9) < 7) begin
          pend[q] = 1'b1;
          req_we[q] = 1'($urandom_range(0, 1));
          req_addr[q] = 3'($urandom_range(0, 7));
          req_wdata[q] = $urandom();
          req_wbe[q] = 4'($urandom_range(0, 15));
        end
      end
      req_valid = pend;
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        ev = e[32] ? 2'b10 : 2'b01;
        n_cmp++;
        if ({rsp_valid, rsp_rdata} !== {ev, e[31:0]}) begin
          n_err++;
          $display("FAIL rnd_rsp%0d: got %h expected %h", c, {rsp_valid, rsp_rdata}, {ev, e[31:0]});
        end
      end else begin
        n_cmp++;
        if (rsp_valid !== 2'b00) begin
          n_err++;
          $display("FAIL rnd_norsp%0d: got rsp_valid=%b expected 00", c, rsp_valid);
        end
      end
      model_arb(pend, g);
      n_cmp++;
      if ({req_ready, sram_cs} !== {g, |g}) begin
        n_err++;
        $display("FAIL rnd_grant%0d: got rdy/cs=%b expected %b", c, {req_ready, sram_cs}, {g, |g});
      end
      if (|g) begin
        p = g[1] ? 1 : 0;
        n_cmp++;
        if ({sram_we, sram_addr} !== {req_we[p], req_addr[p]} ||
            (req_we[p] && {sram_wdata, sram_wbe} !== {req_wdata[p], req_wbe[p]})) begin
          n_err++;
          $display("FAIL rnd_sram%0d: got we/addr/wdata/wbe=%h expected %h", c,
                   {sram_we, sram_addr, sram_wdata, sram_wbe}, {req_we[p], req_addr[p], req_wdata[p], req_wbe[p]});
        end
        if (req_we[p]) model_write(p);
        else exp_q.push_back({1'(p), exp_mem[req_addr[p]]});
        pend[p] = 1'b0;
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_abort();
    bit found;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({sram_cs, init_done} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_run_gate: got cs/done=%b expected 00", {sram_cs, init_done});
    end
    @(negedge clk);
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      #1;
      if (sram_cs && sram_we && sram_addr == 3'd4) found = 1'b1;
    end
    n_cmp++;
    if (found !== 1'b1) begin
      n_err++;
      $display("FAIL abort_reach_row4: got found=%b expected 1", found);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (sram_cs !== 1'b0) begin
      n_err++;
      $display("FAIL abort_cs_low: got %b expected 0", sram_cs);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({sram_cs, dbg_state} !== {1'b0, IDLE}) begin
      n_err++;
      $display("FAIL abort_idle: got cs/state=%b expected %b", {sram_cs, dbg_state}, {1'b0, IDLE});
    end
    test_init("reinit");
  endtask

  task automatic test_reset_inflight();
    logic [1:0] g;
    @(negedge clk);
    req_valid = 2'b01; req_we = 2'b00; req_addr[0] = 3'd2;
    #1;
    model_arb(req_valid, g);
    n_cmp++;
    if (req_ready !== g) begin
      n_err++;
      $display("FAIL inflight_grant: got %b expected %b", req_ready, g);
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({rsp_valid, sram_cs, init_done} !== 4'b0) begin
      n_err++;
      $display("FAIL inflight_suppress: got rsp/cs/done=%b expected 0000", {rsp_valid, sram_cs, init_done});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (rsp_valid !== 2'b00) begin
      n_err++;
      $display("FAIL inflight_after: got %b expected 00", rsp_valid);
    end
    test_init("post_inflight");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int a = 0; a < 8; a++) sram_mem[a] = $urandom();
    sram_rdata = $urandom();
    idle_inputs();
    test_reset();
    test_init("init");
    test_read_zero();
    test_write_read();
    test_back_to_back();
    test_random();
    test_reset_abort();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
